rom_ctrl_scan_counter: RTL and testbench
========================================

ROM_CTRL_SCAN_COUNTER -- requirements
Module: rom_ctrl_scan_counter

Interface
REQ-001 SHALL have parameter RomDepth, default 16, meaning number of ROM words (at least 4).
REQ-002 SHALL have parameter RomTopCount, default 2, meaning top words excluded from the hash; 1 <= RomTopCount <= RomDepth-2.
REQ-003 SHALL have parameter DataWidth, default 40, meaning ROM word width.
REQ-004 SHALL have parameter ReadLatency, default 1, meaning cycles from read_req_o to rom_data_i valid (1..3).
REQ-005 SHALL have port clk_i, input, width 1, meaning the single clock.
REQ-006 SHALL have port rst_ni, input, width 1, meaning reset: synchronous, active-low.
REQ-007 SHALL have port read_req_o, output, width 1, meaning ROM read request.
REQ-008 SHALL have port read_addr_o, output, width AW=vbits(RomDepth), meaning ROM read address.
REQ-009 SHALL have port rom_data_i, input, width DataWidth, meaning ROM read data, ReadLatency cycles after the request.
REQ-010 SHALL have port data_vld_o, output, width 1, meaning a buffered word is presented.
REQ-011 SHALL have port data_rdy_i, input, width 1, meaning the consumer accepts the word.
REQ-012 SHALL have port data_o, output, width DataWidth, meaning the presented word.
REQ-013 SHALL have port data_addr_o, output, width AW, meaning the address of the presented word.
REQ-014 SHALL have port data_last_nontop_o, output, width 1, meaning the presented word is at address RomDepth-RomTopCount-1.
REQ-015 SHALL have port data_top_o, output, width 1, meaning the presented word is at address >= RomDepth-RomTopCount.
REQ-016 SHALL have port restart_i, input, width 1, meaning a rescan request (see REQ-030).
REQ-017 SHALL have port done_o, output, width 1, meaning all RomDepth words were accepted.

Function
REQ-018 SHALL implement FSM states Scan, Drain and Done; Scan SHALL be entered out of reset.
REQ-019 In Scan, SHALL issue a read (read_req_o=1) in any cycle where outstanding+buffered < ReadLatency+1 and next address <= RomDepth-1, then increment the issue address.
REQ-020 SHALL retain each issued address in an in-flight pipeline of depth ReadLatency and SHALL write rom_data_i together with that address into the buffer exactly ReadLatency cycles after issue.
REQ-021 The buffer SHALL never overflow; the credit rule in REQ-019 SHALL guarantee this under any data_rdy_i pattern.
REQ-022 data_vld_o SHALL be the buffer non-empty flag; a word transfers when data_vld_o and data_rdy_i are both 1; data_o and data_addr_o SHALL remain stable while data_vld_o=1 and data_rdy_i=0.
REQ-023 Words SHALL be presented in strictly ascending address order 0..RomDepth-1 without gaps or repeats.
REQ-024 After address RomDepth-1 is issued, SHALL move to Drain and deassert read_req_o.
REQ-025 SHALL move Drain->Done in the cycle after the transfer of address RomDepth-1; done_o SHALL be registered and asserted from that cycle.
REQ-026 With ReadLatency=1 and data_rdy_i held at 1, first data_vld_o SHALL occur in cycle 2 after reset release, with one word per cycle thereafter.
REQ-027 Address arithmetic SHALL be AW bits with no wrap; the issue counter SHALL saturate at RomDepth-1.
REQ-028 In Done, read_req_o and data_vld_o SHALL be 0, and done_o SHALL stay 1 until restart or reset.
REQ-029 A simultaneous buffer write and buffer read SHALL keep the occupancy unchanged.

Reset
REQ-030 With rst_ni=0 at a clock edge: state=Scan; issue address 0; in-flight pipeline and buffer cleared; read_req_o=0; data_vld_o=0; done_o=0; data_last_nontop_o=0; data_top_o=0; data_o=0; data_addr_o=0.
REQ-031 Reset asserted mid-scan SHALL discard all in-flight reads; the following scan SHALL restart at address 0.

Configuration
REQ-032 Macro ROM_CTRL_SCAN_RESTART_EN defined: restart_i=1 in Done SHALL return the FSM to Scan with the REQ-030 values (except state) on the next edge; restart_i in Scan or Drain SHALL be ignored.
REQ-033 Macro undefined: restart_i SHALL be ignored and Done SHALL be terminal until reset.

Structure
REQ-034 Package rom_ctrl_scan_pkg SHALL hold the state enum type and the localparam helper functions for the RomNonTopCount and last-nontop address.
REQ-035 The buffer SHALL be the sub-module rom_ctrl_scan_buf: a synchronous FIFO of depth ReadLatency+1 with width DataWidth+AW, holding data and address.

Verification
REQ-036 RomDepth=16, RomTopCount=2, ReadLatency=1, data_rdy_i=1 -> addresses 0..15 are presented on consecutive cycles; data_last_nontop_o=1 only at address 13; data_top_o=1 at 14 and 15; done_o rises one cycle after address 15 transfers.
REQ-037 ReadLatency=3, data_rdy_i random at 30% -> no word is lost or duplicated; buffer occupancy stays <= 4; data_o matches the ROM model.
REQ-038 data_rdy_i=0 for 20 cycles at address 5 -> data_o and data_addr_o stay at 5; read_req_o stops once credits are exhausted.
REQ-039 rst_ni pulled low for 1 cycle at address 9 -> the next presented word is address 0; done_o stays 0.
REQ-040 With ROM_CTRL_SCAN_RESTART_EN, restart_i pulsed in Done -> done_o drops and a full 0..15 scan repeats; without the macro, the same pulse leaves done_o=1 and read_req_o=0.

Source files
------------

// File: rtl/rom_ctrl_scan_pkg.sv
// Shared types and address helpers for the ROM scan counter.
// Latency: none (types and constant functions only); backpressure: not applicable.
package rom_ctrl_scan_pkg;

    typedef enum logic [1:0] {
        StScan  = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } scan_state_e;

    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int rom_non_top_count(input int depth, input int top_count);
        return depth - top_count;
    endfunction

    function automatic int last_non_top_addr(input int depth, input int top_count);
        return depth - top_count - 1;
    endfunction

endpackage

// File: rtl/rom_ctrl_scan_buf.sv
// Small synchronous FIFO holding {data, address} of returned ROM reads.
// Latency: one cycle write-to-visible; backpressure: rd_rdy low holds the head, writer must respect level.
module rom_ctrl_scan_buf
    import rom_ctrl_scan_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr,
    input  logic                         wr_vld,
    input  logic [Width-1:0]             wr_dat,
    input  logic                         rd_rdy,
    output logic                         rd_vld,
    output logic [Width-1:0]             rd_dat,
    output logic [$clog2(Depth+1)-1:0]   level
);

    localparam int PtrW = vbits(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  cnt;
    logic             push;
    logic             pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign level  = cnt;
    assign pop    = rd_vld && rd_rdy;
    // The upstream credit check guarantees a free slot for every write.
    assign push   = wr_vld;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rom_ctrl_scan_counter.sv
// Sequential ROM scanner: issues reads 0..RomDepth-1 and streams {data, addr} out in order.
// Latency: ReadLatency+1 cycles read-to-present; backpressure via credits; ROM_CTRL_SCAN_RESTART_EN enables rescan from Done.
module rom_ctrl_scan_counter
    import rom_ctrl_scan_pkg::*;
#(
    parameter int  RomDepth    = 16,
    parameter int  RomTopCount = 2,
    parameter int  DataWidth   = 40,
    parameter int  ReadLatency = 1,
    localparam int AW          = vbits(RomDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 read_req_o,
    output logic [AW-1:0]        read_addr_o,
    input  logic [DataWidth-1:0] rom_data_i,
    output logic                 data_vld_o,
    input  logic                 data_rdy_i,
    output logic [DataWidth-1:0] data_o,
    output logic [AW-1:0]        data_addr_o,
    output logic                 data_last_nontop_o,
    output logic                 data_top_o,
    input  logic                 restart_i,
    output logic                 done_o
);

    localparam int BufDepth   = ReadLatency + 1;
    localparam int CntW       = $clog2(BufDepth + 1);
    localparam int LastAddr   = RomDepth - 1;
    localparam int LastNonTop = last_non_top_addr(RomDepth, RomTopCount);
    localparam int FirstTop   = rom_non_top_count(RomDepth, RomTopCount);

    scan_state_e            state;
    logic [AW-1:0]          issue_addr;
    logic                   pipe_vld  [ReadLatency];
    logic [AW-1:0]          pipe_addr [ReadLatency];
    logic [CntW-1:0]        inflight;
    logic [CntW-1:0]        buf_level;
    logic [CntW:0]          used;
    logic                   issue;
    logic                   buf_pop;
    logic                   restart_req;
    logic [DataWidth+AW-1:0] buf_rdat;

`ifdef ROM_CTRL_SCAN_RESTART_EN
    assign restart_req = (state == StDone) && restart_i;
`else
    logic unused_restart;
    assign restart_req    = 1'b0;
    assign unused_restart = restart_i;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            inflight = inflight + CntW'(pipe_vld[i]);
        end
    end

    // A word popped this cycle frees its slot immediately, which keeps one word per cycle at full rate.
    assign used    = {1'b0, inflight} + {1'b0, buf_level} - (CntW+1)'(buf_pop);
    assign issue   = rst_ni && (state == StScan) && (used < (CntW+1)'(BufDepth));
    assign buf_pop = data_vld_o && data_rdy_i;

    assign read_req_o  = issue;
    assign read_addr_o = issue_addr;

    rom_ctrl_scan_buf #(
        .Depth (BufDepth),
        .Width (DataWidth + AW)
    ) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (restart_req),
        .wr_vld (pipe_vld[ReadLatency-1]),
        .wr_dat ({rom_data_i, pipe_addr[ReadLatency-1]}),
        .rd_rdy (data_rdy_i),
        .rd_vld (data_vld_o),
        .rd_dat (buf_rdat),
        .level  (buf_level)
    );

    assign data_o             = buf_rdat[DataWidth+AW-1:AW];
    assign data_addr_o        = buf_rdat[AW-1:0];
    assign data_last_nontop_o = data_vld_o && (data_addr_o == AW'(LastNonTop));
    assign data_top_o         = data_vld_o && (data_addr_o >= AW'(FirstTop));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || restart_req) begin
            state      <= StScan;
            issue_addr <= '0;
            done_o     <= 1'b0;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_addr[0] <= issue_addr;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
            case (state)
                StScan: begin
                    if (issue) begin
                        if (issue_addr == AW'(LastAddr)) begin
                            state <= StDrain;
                        end else begin
                            issue_addr <= issue_addr + AW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (buf_pop && (data_addr_o == AW'(LastAddr))) begin
                        state  <= StDone;
                        done_o <= 1'b1;
                    end
                end
                StDone:  state <= StDone;
                default: state <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_ctrl_scan_counter.sv
// Directed bench for rom_ctrl_scan_counter: ReadLatency=1 instance for timing/stall/reset/restart,
// ReadLatency=3 instance under random backpressure.
module tb_rom_ctrl_scan_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req1, vld1, rdy1, last1, top1, restart1, done1;
    logic [3:0]  raddr1, daddr1;
    logic [39:0] rdata1, dat1;

    logic        req3, vld3, rdy3, last3, top3, restart3, done3;
    logic [3:0]  raddr3, daddr3;
    logic [39:0] rdata3, dat3;
    logic [39:0] rom3_pipe [3];

    int errs   = 0;
    int checks = 0;

    rom_ctrl_scan_counter #(
        .RomDepth(16), .RomTopCount(2), .DataWidth(40), .ReadLatency(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .read_req_o(req1), .read_addr_o(raddr1),
        .rom_data_i(rdata1), .data_vld_o(vld1), .data_rdy_i(rdy1), .data_o(dat1),
        .data_addr_o(daddr1), .data_last_nontop_o(last1), .data_top_o(top1),
        .restart_i(restart1), .done_o(done1)
    );

    rom_ctrl_scan_counter #(
        .RomDepth(16), .RomTopCount(2), .DataWidth(40), .ReadLatency(3)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .read_req_o(req3), .read_addr_o(raddr3),
        .rom_data_i(rdata3), .data_vld_o(vld3), .data_rdy_i(rdy3), .data_o(dat3),
        .data_addr_o(daddr3), .data_last_nontop_o(last3), .data_top_o(top3),
        .restart_i(restart3), .done_o(done3)
    );

    function automatic logic [39:0] rom_word(input logic [3:0] a);
        logic [7:0]  hi;
        logic [31:0] lo;
        hi = {a, ~a} ^ 8'h5C;
        lo = 32'h9E37_79B9 * (32'(a) + 32'd1);
        return {hi, lo};
    endfunction

    // ROM models: data for the address requested appears ReadLatency cycles later
    always @(posedge clk) begin
        rdata1       <= rom_word(raddr1);
        rom3_pipe[0] <= rom_word(raddr3);
        rom3_pipe[1] <= rom3_pipe[0];
        rom3_pipe[2] <= rom3_pipe[1];
    end
    assign rdata3 = rom3_pipe[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rdy1     = 1'b0;
        rdy3     = 1'b0;
        restart1 = 1'b0;
        restart3 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic       rdy;
        logic       req;
        logic [3:0] raddr;
        logic       vld;
        logic [3:0] daddr;
        logic       last;
        logic       top;
        logic       done;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int n;
        int expn;
        int issued;
        logic prev_stall;
        logic [3:0]  prev_addr;
        logic [39:0] prev_dat;

        //             rdy req raddr  vld daddr  last top done
        tbl[0]  = '{1, 1, 4'd0,  0, 4'd0,  0, 0, 0};
        tbl[1]  = '{1, 1, 4'd1,  0, 4'd0,  0, 0, 0};
        tbl[2]  = '{1, 1, 4'd2,  1, 4'd0,  0, 0, 0};
        tbl[3]  = '{1, 1, 4'd3,  1, 4'd1,  0, 0, 0};
        tbl[4]  = '{1, 1, 4'd4,  1, 4'd2,  0, 0, 0};
        tbl[5]  = '{1, 1, 4'd5,  1, 4'd3,  0, 0, 0};
        tbl[6]  = '{1, 1, 4'd6,  1, 4'd4,  0, 0, 0};
        tbl[7]  = '{1, 1, 4'd7,  1, 4'd5,  0, 0, 0};
        tbl[8]  = '{1, 1, 4'd8,  1, 4'd6,  0, 0, 0};
        tbl[9]  = '{1, 1, 4'd9,  1, 4'd7,  0, 0, 0};
        tbl[10] = '{1, 1, 4'd10, 1, 4'd8,  0, 0, 0};
        tbl[11] = '{1, 1, 4'd11, 1, 4'd9,  0, 0, 0};
        tbl[12] = '{1, 1, 4'd12, 1, 4'd10, 0, 0, 0};
        tbl[13] = '{1, 1, 4'd13, 1, 4'd11, 0, 0, 0};
        tbl[14] = '{1, 1, 4'd14, 1, 4'd12, 0, 0, 0};
        tbl[15] = '{1, 1, 4'd15, 1, 4'd13, 1, 0, 0};
        tbl[16] = '{1, 0, 4'd0,  1, 4'd14, 0, 1, 0};
        tbl[17] = '{1, 0, 4'd0,  1, 4'd15, 0, 1, 0};
        tbl[18] = '{1, 0, 4'd0,  0, 4'd0,  0, 0, 1};
        tbl[19] = '{1, 0, 4'd0,  0, 4'd0,  0, 0, 1};

        // Reset state
        do_reset();
        #1;
        chk("rst req", req1, 0);
        chk("rst vld", vld1, 0);
        chk("rst done", done1, 0);
        chk("rst last", last1, 0);
        chk("rst top", top1, 0);
        chk("rst data", dat1, 0);
        chk("rst addr", daddr1, 0);
        chk("rst req3", req3, 0);
        chk("rst vld3", vld3, 0);

        // Full-rate scan, one table row per cycle from reset release
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            rdy1 = tbl[c].rdy;
            #1;
            chk($sformatf("scan c%0d req", c), req1, tbl[c].req);
            if (tbl[c].req) chk($sformatf("scan c%0d raddr", c), raddr1, tbl[c].raddr);
            chk($sformatf("scan c%0d vld", c), vld1, tbl[c].vld);
            if (tbl[c].vld) begin
                chk($sformatf("scan c%0d daddr", c), daddr1, tbl[c].daddr);
                chk($sformatf("scan c%0d data", c), dat1, rom_word(tbl[c].daddr));
            end
            chk($sformatf("scan c%0d last", c), last1, tbl[c].last);
            chk($sformatf("scan c%0d top", c), top1, tbl[c].top);
            chk($sformatf("scan c%0d done", c), done1, tbl[c].done);
        end

        // Stall at address 5 for 20 cycles, then drain the rest in order
        do_reset();
        rst_n = 1'b1;
        rdy1  = 1'b1;
        n = 0;
        while (!(vld1 && daddr1 == 4'd5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall reach addr5", n < 40, 1);
        rdy1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("stall %0d vld", i), vld1, 1);
            chk($sformatf("stall %0d addr", i), daddr1, 5);
            chk($sformatf("stall %0d data", i), dat1, rom_word(4'd5));
            if (i >= 1) chk($sformatf("stall %0d req", i), req1, 0);
            @(negedge clk);
        end
        rdy1 = 1'b1;
        expn = 5;
        n = 0;
        while (!done1 && n < 60) begin
            #1;
            if (vld1) begin
                chk("resume addr", daddr1, expn[3:0]);
                chk("resume data", dat1, rom_word(expn[3:0]));
                expn++;
            end
            @(negedge clk);
            n++;
        end
        chk("resume count", expn, 16);
        chk("resume done", done1, 1);

        // Reset pulse while address 9 is presented
        do_reset();
        rst_n = 1'b1;
        rdy1  = 1'b1;
        n = 0;
        while (!(vld1 && daddr1 == 4'd9) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrst reach addr9", n < 40, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst vld", vld1, 0);
        chk("midrst done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!vld1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("midrst first cycle", n, 2);
        chk("midrst first addr", daddr1, 0);
        chk("midrst first data", dat1, rom_word(4'd0));
        chk("midrst done low", done1, 0);

        // Run to Done, then pulse restart
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to done", done1, 1);
        restart1 = 1'b1;
        @(negedge clk);
        restart1 = 1'b0;
        #1;
`ifdef ROM_CTRL_SCAN_RESTART_EN
        chk("restart done drop", done1, 0);
        expn = 0;
        n = 0;
        while (!done1 && n < 60) begin
            if (vld1) begin
                chk("rescan addr", daddr1, expn[3:0]);
                chk("rescan data", dat1, rom_word(expn[3:0]));
                expn++;
            end
            @(negedge clk);
            #1;
            n++;
        end
        chk("rescan count", expn, 16);
        chk("rescan done", done1, 1);
`else
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("restart ign %0d done", i), done1, 1);
            chk($sformatf("restart ign %0d req", i), req1, 0);
            chk($sformatf("restart ign %0d vld", i), vld1, 0);
            @(negedge clk);
            #1;
        end
`endif

        // ReadLatency=3 under ~30% ready
        do_reset();
        rst_n      = 1'b1;
        expn       = 0;
        issued     = 0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_dat   = '0;
        for (int c = 0; c < 600 && !done3; c++) begin
            if (c > 0) @(negedge clk);
            rdy3 = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_stall) begin
                chk("rand hold vld", vld3, 1);
                chk("rand hold addr", daddr3, prev_addr);
                chk("rand hold data", dat3, prev_dat);
            end
            if (req3) begin
                chk("rand issue addr", raddr3, issued);
                issued++;
            end
            if (vld3 && rdy3) begin
                chk("rand addr", daddr3, expn[3:0]);
                chk("rand data", dat3, rom_word(expn[3:0]));
                expn++;
            end
            chk("rand credit", (issued - expn) <= 4, 1);
            prev_stall = vld3 && !rdy3;
            prev_addr  = daddr3;
            prev_dat   = dat3;
        end
        @(negedge clk);
        #1;
        chk("rand done", done3, 1);
        chk("rand words", expn, 16);
        chk("rand issued", issued, 16);
        chk("rand vld after done", vld3, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
